// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI serializer.
//  - Default frame/divider/gap sizes used as parameter defaults by the top.
//  - FSM state encoding shared by the top and anything that decodes it.
package dac_spi_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int DIV_W_DEF      = 8;
    localparam int CS_GAP_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,  // waiting for a sample, s_ready high
        ST_SETUP = 3'd1,  // cs_n low, MSB on din, sclk low for one half period
        ST_SHIFT = 3'd2,  // sclk toggling, one bit per full period
        ST_HOLD  = 3'd3,  // sclk low, cs_n still low for one half period
        ST_GAP   = 3'd4   // cs_n high inter-frame gap
    } state_t;

endpackage

// File: rtl/dac_spi_tick_gen.sv
// Half-period tick generator for the SPI clock.
//  clk, reset_n : system clock, async active-low reset
//  load         : start of frame, counter takes load_val
//  load_val     : divider value sampled at frame accept
//  en           : count while a frame is active
//  reload       : value restored after each tick (latched divider)
//  tick         : high for one cycle every reload+1 enabled cycles
module dac_spi_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Tick on the zero count; the reload on that same edge means the
    // counter never decrements past zero.
    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (cnt == '0) cnt <= reload;
            else           cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Streams DATA_W-bit samples to an external SPI DAC, MSB first.
//  clk, reset_n : system clock, async active-low reset
//  div          : SCLK divider, half period = div+1 clk cycles, sampled at accept
//  s_valid/s_ready/s_data : sample input handshake
//  dac_sclk/dac_din/dac_cs_n : SPI pins (sclk idle low, DAC samples on rising edge)
//  busy         : high from accept until s_ready returns
//  done         : one-cycle pulse as cs_n returns high
// Every output is a flop; nothing combinational reaches a port.
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int CS_GAP_CYC = CS_GAP_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              dac_cs_n,
    output logic              busy,
    output logic              done
);

    localparam int BCNT_W = $clog2(DATA_W) + 1;
    localparam int GAP_W  = $clog2(CS_GAP_CYC + 1);

    state_t              state, state_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [DIV_W-1:0]    div_q, div_q_d;
    logic [BCNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic                sclk_d, din_d, cs_n_d, ready_d, busy_d, done_d;
    logic                tick, tick_load, tick_en;

    dac_spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tick_load),
        .load_val (div),
        .en       (tick_en),
        .reload   (div_q),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            div_q    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            s_ready  <= 1'b0;
            dac_sclk <= 1'b0;
            dac_din  <= 1'b0;
            dac_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            div_q    <= div_q_d;
            bit_cnt  <= bit_cnt_d;
            gap_cnt  <= gap_cnt_d;
            s_ready  <= ready_d;
            dac_sclk <= sclk_d;
            dac_din  <= din_d;
            dac_cs_n <= cs_n_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        div_q_d   = div_q;
        bit_cnt_d = bit_cnt;
        gap_cnt_d = gap_cnt;
        ready_d   = s_ready;
        sclk_d    = dac_sclk;
        din_d     = dac_din;
        cs_n_d    = dac_cs_n;
        busy_d    = busy;
        done_d    = 1'b0;
        tick_load = 1'b0;
        tick_en   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (s_valid && s_ready) begin
                    state_d   = ST_SETUP;
                    shreg_d   = s_data;
                    div_q_d   = div;
                    tick_load = 1'b1;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    din_d     = s_data[DATA_W-1];
                end
            end
            ST_SETUP: begin
                tick_en = 1'b1;
                if (tick) begin
                    state_d   = ST_SHIFT;
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt + BCNT_W'(1);
                end
            end
            ST_SHIFT: begin
                tick_en = 1'b1;
                if (tick) begin
                    if (dac_sclk) begin
                        // Falling edge: present the next bit unless the word is spent.
                        sclk_d = 1'b0;
                        if (bit_cnt != BCNT_W'(DATA_W)) begin
                            shreg_d = shreg << 1;
                            din_d   = shreg[DATA_W-2];
                        end
                    end else if (bit_cnt == BCNT_W'(DATA_W)) begin
                        // Last low half period finished; sclk stays low into HOLD.
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt + BCNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                tick_en = 1'b1;
                if (tick) begin
                    state_d   = ST_GAP;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = GAP_W'(CS_GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Self-checking bench for dac_spi_serializer.
module tb_dac_spi_serializer;

    localparam int DATA_W = 16;
    localparam int DIV_W  = 8;
    localparam int GAP    = 2;
    localparam int BUDGET = 10000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DIV_W-1:0]  div = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready, dac_sclk, dac_din, dac_cs_n, busy, done;

    dac_spi_serializer #(.DATA_W(DATA_W), .DIV_W(DIV_W), .CS_GAP_CYC(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .div(div), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_cs_n(dac_cs_n),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- pin monitor: reconstructs each frame from the wires
    int   cs_low, rises, run, hmin, hmax, lmin, lmax, cs_high;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, had_frame = 1'b0;
    logic [DATA_W-1:0] rx;
    int   frames = 0, done_cnt = 0, done_aligned = 0, last_gap = -1;
    int   l_word, l_rises, l_cs_low, l_hmin, l_hmax, l_lmin, l_lmax;
    int   acc_q[$];
    int   word_q[$];

    function automatic void rec(input logic lvl, input int n);
        if (lvl) begin
            if (n < hmin) hmin = n;
            if (n > hmax) hmax = n;
        end else begin
            if (n < lmin) lmin = n;
            if (n > lmax) lmax = n;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; had_frame = 1'b0; cs_high = 0;
        end else begin
            if (s_valid && s_ready) acc_q.push_back(cyc);
            if (!dac_cs_n) begin
                if (prev_cs) begin
                    if (had_frame) last_gap = cs_high;
                    cs_low = 0; rises = 0; run = 0; rx = '0;
                    hmin = 1 << 30; hmax = 0; lmin = 1 << 30; lmax = 0;
                end else if (dac_sclk != prev_sclk) begin
                    rec(prev_sclk, run);
                    run = 0;
                end
                if (dac_sclk && !prev_sclk) begin
                    rx = {rx[DATA_W-2:0], dac_din};
                    rises++;
                end
                cs_low++;
                run++;
            end else begin
                if (!prev_cs) begin
                    rec(prev_sclk, run);
                    l_word = int'(rx); l_rises = rises; l_cs_low = cs_low;
                    l_hmin = hmin; l_hmax = hmax; l_lmin = lmin; l_lmax = lmax;
                    word_q.push_back(int'(rx));
                    if (done) done_aligned++;
                    frames++;
                    had_frame = 1'b1;
                    cs_high = 0;
                end
                cs_high++;
            end
            if (done) done_cnt++;
            prev_cs = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    // ---------------- checking helpers
    int exp_done = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input logic [DIV_W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < BUDGET) begin @(negedge clk); n++; end
        chk("send_ready", int'(s_ready), 1);
        s_data = w; div = d; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames < target && n < BUDGET) begin @(posedge clk); #1; n++; end
        chk("frame_timeout", int'(frames >= target), 1);
    endtask

    // Expected frame shape from the protocol: 16 rising edges carrying the
    // word MSB first, every sclk phase = div+1 cycles, the final low phase
    // also covers the HOLD half period, cs_n low for (2*DATA_W+2) halves.
    task automatic check_frame(input string tag, input logic [DATA_W-1:0] w, input int d);
        int h;
        h = d + 1;
        exp_done++;
        chk({tag, "_word"},   l_word,   int'(w));
        chk({tag, "_rises"},  l_rises,  DATA_W);
        chk({tag, "_cslow"},  l_cs_low, (2 * DATA_W + 2) * h);
        chk({tag, "_hmin"},   l_hmin,   h);
        chk({tag, "_hmax"},   l_hmax,   h);
        chk({tag, "_lmin"},   l_lmin,   h);
        chk({tag, "_lmax"},   l_lmax,   2 * h);
        chk({tag, "_done"},   done_cnt, exp_done);
        chk({tag, "_donept"}, done_aligned, exp_done);
    endtask

    task automatic check_idle(input string tag);
        repeat (GAP + 2) @(negedge clk);
        chk({tag, "_ready"}, int'(s_ready),  1);
        chk({tag, "_busy"},  int'(busy),     0);
        chk({tag, "_csn"},   int'(dac_cs_n), 1);
        chk({tag, "_sclk"},  int'(dac_sclk), 0);
    endtask

    // ---------------- directed sequence
    initial begin
        logic [DATA_W-1:0] w3 [3];
        logic [DATA_W-1:0] rw;
        int fb, ab, dc, rd, n;

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(s_ready),  0);
        chk("rst_sclk",  int'(dac_sclk), 0);
        chk("rst_din",   int'(dac_din),  0);
        chk("rst_csn",   int'(dac_cs_n), 1);
        chk("rst_busy",  int'(busy),     0);
        chk("rst_done",  int'(done),     0);
        reset_n = 1'b1;
        #1 chk("rel_ready_pre", int'(s_ready), 0);
        @(negedge clk);
        chk("rel_ready_post", int'(s_ready), 1);

        // 1: fastest clock, mixed pattern
        fb = frames;
        send(16'hA5C3, 8'd0);
        chk("t1_busy",  int'(busy),     1);
        chk("t1_ready", int'(s_ready),  0);
        chk("t1_csn",   int'(dac_cs_n), 0);
        chk("t1_din0",  int'(dac_din),  1);
        wait_frames(fb + 1);
        check_frame("t1", 16'hA5C3, 0);
        check_idle("t1");

        // 2: div=3, only end bits set
        fb = frames;
        send(16'h8001, 8'd3);
        wait_frames(fb + 1);
        check_frame("t2", 16'h8001, 3);

        // 3: back-to-back with s_valid held
        w3[0] = 16'h1234; w3[1] = 16'hFEDC; w3[2] = 16'h0F0F;
        fb = frames; ab = acc_q.size();
        @(negedge clk);
        n = 0;
        while (!s_ready && n < BUDGET) begin @(negedge clk); n++; end
        s_data = w3[0]; div = 8'd0; s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!s_ready && n < BUDGET) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            if (k < 2) s_data = w3[k + 1];
        end
        s_valid = 1'b0;
        wait_frames(fb + 3);
        chk("t3_nacc", acc_q.size() - ab, 3);
        if (acc_q.size() - ab == 3) begin
            chk("t3_acc01", acc_q[ab + 1] - acc_q[ab],     (2 * DATA_W + 2) + GAP + 1);
            chk("t3_acc12", acc_q[ab + 2] - acc_q[ab + 1], (2 * DATA_W + 2) + GAP + 1);
        end
        for (int k = 0; k < 3; k++)
            if (word_q.size() >= 3)
                chk($sformatf("t3_word%0d", k), word_q[word_q.size() - 3 + k], int'(w3[k]));
        chk("t3_gap", int'(last_gap >= GAP), 1);
        exp_done += 3;
        chk("t3_done", done_cnt, exp_done);

        // 4: divider changed mid-frame only takes effect on the next accept
        fb = frames;
        send(16'h3C5A, 8'd1);
        repeat (10) @(negedge clk);
        div = 8'd7;
        wait_frames(fb + 1);
        check_frame("t4a", 16'h3C5A, 1);
        send(16'hC3A5, 8'd7);
        wait_frames(fb + 2);
        check_frame("t4b", 16'hC3A5, 7);

        // 5: reset in the middle of bit 5
        fb = frames; dc = done_cnt;
        send(16'h5AA5, 8'd2);
        n = 0;
        while (rises < 5 && n < BUDGET) begin @(posedge clk); #1; n++; end
        chk("t5_reach_bit5", int'(rises >= 5), 1);
        chk("t5_csn_before", int'(dac_cs_n), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_csn_now",  int'(dac_cs_n), 1);
        chk("t5_sclk_now", int'(dac_sclk), 0);
        chk("t5_busy_now", int'(busy),     0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_no_done",  done_cnt, dc);
        chk("t5_no_frame", frames,   fb);
        send(16'hB00B, 8'd2);
        wait_frames(fb + 1);
        check_frame("t5", 16'hB00B, 2);

        // 6: slowest clock, all ones
        fb = frames;
        send(16'hFFFF, 8'd255);
        wait_frames(fb + 1);
        check_frame("t6", 16'hFFFF, 255);
        check_idle("t6");

        // random words and dividers
        for (int r = 0; r < 6; r++) begin
            rw = DATA_W'($urandom);
            rd = int'($urandom_range(0, 4));
            fb = frames;
            send(rw, DIV_W'(rd));
            wait_frames(fb + 1);
            check_frame($sformatf("rnd%0d", r), rw, rd);
        end
        check_idle("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
